// File: rtl/vc_arbiter_pkg.sv
// Shared definitions for the virtual-channel arbiter: state encodings and
// default datapath geometry.
package vc_arbiter_pkg;

    localparam int BW_DEFAULT = 6;
    localparam int WW_DEFAULT = 4;

    // The word MSB selects the destination FIFO (0 -> D0, 1 -> D1).
    localparam int DEST_BIT = BW_DEFAULT - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/vc_output_stage.sv
// Two-stage output pipeline: tracks popped words, captures the VC FIFO read
// data one cycle after the pop and steers it into the selected destination.
module vc_output_stage
    import vc_arbiter_pkg::*;
#(
    parameter int BW   = BW_DEFAULT,
    parameter int DEST = DEST_BIT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vc0_pop,
    input  logic          vc1_pop,
    input  logic [BW-1:0] vc0_data,
    input  logic [BW-1:0] vc1_data,
    output logic          d0_push,
    output logic          d1_push,
    output logic [BW-1:0] d_data
);

    logic          valid_s1;
    logic          sel_s1;
    logic          valid_s2;
    logic [BW-1:0] data_s2;

    // The pops are mutually exclusive, so the VC1 strobe alone identifies the source.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_s1 <= 1'b0;
            sel_s1   <= 1'b0;
        end else begin
            valid_s1 <= vc0_pop | vc1_pop;
            sel_s1   <= vc1_pop;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_s2 <= 1'b0;
            data_s2  <= '0;
        end else begin
            valid_s2 <= valid_s1;
            if (valid_s1) begin
                data_s2 <= sel_s1 ? vc1_data : vc0_data;
            end
        end
    end

    assign d_data  = data_s2;
    assign d0_push = valid_s2 & ~data_s2[DEST];
    assign d1_push = valid_s2 &  data_s2[DEST];

endmodule

// File: rtl/vc_arbiter.sv
// Weighted round-robin scheduler between two VC FIFOs feeding two destination
// FIFOs through a registered two-stage pipeline.
module vc_arbiter
    import vc_arbiter_pkg::*;
#(
    parameter int BW = BW_DEFAULT,
    parameter int WW = WW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          active,
    input  logic [WW-1:0] weight_vc0,
    input  logic [WW-1:0] weight_vc1,
    input  logic          vc0_empty,
    input  logic          vc1_empty,
    input  logic [BW-1:0] vc0_data,
    input  logic [BW-1:0] vc1_data,
    output logic          vc0_pop,
    output logic          vc1_pop,
    input  logic          d0_almost_full,
    input  logic          d1_almost_full,
    output logic          d0_push,
    output logic          d1_push,
    output logic [BW-1:0] d_data,
    output logic [1:0]    present_state,
    output logic          stall
);

    arb_state_t    state;
    arb_state_t    state_next;
    logic [WW-1:0] credit;
    logic [WW-1:0] credit_next;
    logic          pop0_next;
    logic          pop1_next;
    logic          stall_next;

    logic          blocked;
    logic          serving;
    logic          on_vc1;
    logic          own_empty;
    logic          other_empty;
    logic [WW-1:0] own_load;
    logic [WW-1:0] other_load;
    logic          pop_own;
    logic          turn_end;

    function automatic logic [WW-1:0] load_weight(input logic [WW-1:0] w);
        return (w == '0) ? WW'(1) : w;
    endfunction

    // The destination of the next word is unknown until it is read, so
    // either almost-full flag withholds pops.
    assign blocked = d0_almost_full | d1_almost_full;

    assign serving     = (state == SERVE0) || (state == SERVE1);
    assign on_vc1      = (state == SERVE1);
    assign own_empty   = on_vc1 ? vc1_empty : vc0_empty;
    assign other_empty = on_vc1 ? vc0_empty : vc1_empty;
    assign own_load    = load_weight(on_vc1 ? weight_vc1 : weight_vc0);
    assign other_load  = load_weight(on_vc1 ? weight_vc0 : weight_vc1);

    always_comb begin
        state_next  = state;
        credit_next = credit;
        stall_next  = 1'b0;
        pop_own     = 1'b0;
        turn_end    = 1'b0;

        if (!serving) begin
            if (active && !vc0_empty) begin
                state_next  = SERVE0;
                credit_next = load_weight(weight_vc0);
            end else if (active && !vc1_empty) begin
                state_next  = SERVE1;
                credit_next = load_weight(weight_vc1);
            end
        end else if (!active) begin
            state_next  = IDLE;
            credit_next = '0;
        end else if (own_empty) begin
            turn_end = 1'b1;
        end else if (blocked) begin
            stall_next = 1'b1;
        end else begin
            pop_own = 1'b1;
            if (credit <= WW'(1)) begin
                turn_end = 1'b1;
            end else begin
                credit_next = credit - WW'(1);
            end
        end

        // Prefer the other VC at the end of a turn; a pop issued this cycle
        // has not yet been reflected in the empty flags.
        if (turn_end) begin
            if (!other_empty) begin
                state_next  = on_vc1 ? SERVE0 : SERVE1;
                credit_next = other_load;
            end else if (!own_empty) begin
                credit_next = own_load;
            end else begin
                state_next  = IDLE;
                credit_next = '0;
            end
        end
    end

    assign pop0_next = pop_own & ~on_vc1;
    assign pop1_next = pop_own &  on_vc1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            credit  <= '0;
            vc0_pop <= 1'b0;
            vc1_pop <= 1'b0;
            stall   <= 1'b0;
        end else begin
            state   <= state_next;
            credit  <= credit_next;
            vc0_pop <= pop0_next;
            vc1_pop <= pop1_next;
            stall   <= stall_next;
        end
    end

    assign present_state = state;

    vc_output_stage #(
        .BW   (BW),
        .DEST (BW - 1)
    ) u_output_stage (
        .clk      (clk),
        .reset    (reset),
        .vc0_pop  (vc0_pop),
        .vc1_pop  (vc1_pop),
        .vc0_data (vc0_data),
        .vc1_data (vc1_data),
        .d0_push  (d0_push),
        .d1_push  (d1_push),
        .d_data   (d_data)
    );

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed self-checking bench for vc_arbiter; VC FIFO read data is supplied
// from small word tables one cycle after each pop.
module tb_vc_arbiter;

    localparam int BW = 6;
    localparam int WW = 4;

    logic          clk;
    logic          reset;
    logic          active;
    logic [WW-1:0] weight_vc0;
    logic [WW-1:0] weight_vc1;
    logic          vc0_empty;
    logic          vc1_empty;
    logic [BW-1:0] vc0_data;
    logic [BW-1:0] vc1_data;
    logic          vc0_pop;
    logic          vc1_pop;
    logic          d0_almost_full;
    logic          d1_almost_full;
    logic          d0_push;
    logic          d1_push;
    logic [BW-1:0] d_data;
    logic [1:0]    present_state;
    logic          stall;

    int   check_count = 0;
    int   fail_count  = 0;
    int   rd0;
    int   rd1;
    logic pend0;
    logic pend1;

    logic [BW-1:0] words0 [8] = '{6'h25, 6'h0A, 6'h33, 6'h14, 6'h3F, 6'h01, 6'h2A, 6'h15};
    logic [BW-1:0] words1 [8] = '{6'h07, 6'h38, 6'h19, 6'h26, 6'h0C, 6'h31, 6'h1E, 6'h2D};

    vc_arbiter #(
        .BW (BW),
        .WW (WW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .active         (active),
        .weight_vc0     (weight_vc0),
        .weight_vc1     (weight_vc1),
        .vc0_empty      (vc0_empty),
        .vc1_empty      (vc1_empty),
        .vc0_data       (vc0_data),
        .vc1_data       (vc1_data),
        .vc0_pop        (vc0_pop),
        .vc1_pop        (vc1_pop),
        .d0_almost_full (d0_almost_full),
        .d1_almost_full (d1_almost_full),
        .d0_push        (d0_push),
        .d1_push        (d1_push),
        .d_data         (d_data),
        .present_state  (present_state),
        .stall          (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; a word popped last cycle appears on the read data now.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pend0) begin
            vc0_data = words0[rd0 % 8];
            rd0++;
        end
        if (pend1) begin
            vc1_data = words1[rd1 % 8];
            rd1++;
        end
        pend0 = vc0_pop;
        pend1 = vc1_pop;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rd0   = 0;
        rd1   = 0;
        pend0 = 1'b0;
        pend1 = 1'b0;
    endtask

    // Expected vector layout: {present_state[1:0], vc0_pop, vc1_pop, d0_push, d1_push, stall}
    task automatic check_output(input string tag, input logic [6:0] expected);
        logic [6:0] observed;
        observed = {present_state, vc0_pop, vc1_pop, d0_push, d1_push, stall};
        check_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic check_data(input string tag, input logic [BW-1:0] expected);
        check_count++;
        assert (d_data === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed d_data %h expected %h", tag, d_data, expected);
        end
    endtask

    initial begin
        $display("[TB] starting vc_arbiter directed sequence");
        do_reset();
        active         = 1'b0;
        weight_vc0     = 4'd3;
        weight_vc1     = 4'd1;
        vc0_empty      = 1'b1;
        vc1_empty      = 1'b1;
        vc0_data       = '0;
        vc1_data       = '0;
        d0_almost_full = 1'b0;
        d1_almost_full = 1'b0;
        tick();
        tick();
        check_output("reset_state", 7'b00_00000);
        check_data("reset_d_data", 6'h00);

        // Weighted round robin 3:1 with both VCs holding data.
        reset     = 1'b1;
        active    = 1'b1;
        vc0_empty = 1'b0;
        vc1_empty = 1'b0;
        tick(); check_output("wrr_c1", 7'b01_00000);
        tick(); check_output("wrr_c2", 7'b01_10000);
        tick(); check_output("wrr_c3", 7'b01_10000);
        tick(); check_output("wrr_c4", 7'b10_10010); check_data("wrr_d4", 6'h25);
        tick(); check_output("wrr_c5", 7'b01_01100); check_data("wrr_d5", 6'h0A);
        tick(); check_output("wrr_c6", 7'b01_10010); check_data("wrr_d6", 6'h33);
        tick(); check_output("wrr_c7", 7'b01_10100); check_data("wrr_d7", 6'h07);
        tick(); check_output("wrr_c8", 7'b10_10100); check_data("wrr_d8", 6'h14);
        tick(); check_output("wrr_c9", 7'b01_01010); check_data("wrr_d9", 6'h3F);
        tick(); check_output("wrr_c10", 7'b01_10100); check_data("wrr_d10", 6'h01);
        tick(); check_output("wrr_c11", 7'b01_10010); check_data("wrr_d11", 6'h38);

        // Reset in the middle of the stream clears everything at once.
        do_reset();
        #1;
        check_output("rst_same_cycle", 7'b00_00000);
        check_data("rst_same_cycle_data", 6'h00);
        tick(); check_output("rst_held", 7'b00_00000);
        reset     = 1'b1;
        active    = 1'b0;
        vc0_empty = 1'b1;
        vc1_empty = 1'b1;
        tick(); check_output("rst_release1", 7'b00_00000);
        tick(); check_output("rst_release2", 7'b00_00000);

        // Only VC1 has data and its weight is zero: one pop every cycle.
        weight_vc1 = 4'd0;
        vc1_empty  = 1'b0;
        active     = 1'b1;
        tick(); check_output("vc1_d1", 7'b10_00000);
        tick(); check_output("vc1_d2", 7'b10_01000);
        tick(); check_output("vc1_d3", 7'b10_01000);
        tick(); check_output("vc1_d4", 7'b10_01100); check_data("vc1_data4", 6'h07);
        tick(); check_output("vc1_d5", 7'b10_01010); check_data("vc1_data5", 6'h38);
        tick(); check_output("vc1_d6", 7'b10_01100); check_data("vc1_data6", 6'h19);

        // Backpressure from D1 in the middle of a VC0 turn.
        do_reset();
        active     = 1'b0;
        vc0_empty  = 1'b1;
        vc1_empty  = 1'b1;
        weight_vc0 = 4'd3;
        weight_vc1 = 4'd1;
        tick(); check_output("blk_reset", 7'b00_00000); check_data("blk_reset_data", 6'h00);
        reset     = 1'b1;
        active    = 1'b1;
        vc0_empty = 1'b0;
        vc1_empty = 1'b0;
        tick(); check_output("blk_e1", 7'b01_00000);
        tick(); check_output("blk_e2", 7'b01_10000);
        tick(); check_output("blk_e3", 7'b01_10000);
        d1_almost_full = 1'b1;
        tick(); check_output("blk_e4", 7'b01_00011); check_data("blk_d4", 6'h25);
        tick(); check_output("blk_e5", 7'b01_00101); check_data("blk_d5", 6'h0A);
        tick(); check_output("blk_e6", 7'b01_00001);
        d1_almost_full = 1'b0;
        tick(); check_output("blk_e7", 7'b10_10000);
        tick(); check_output("blk_e8", 7'b01_01000);
        tick(); check_output("blk_e9", 7'b01_10010); check_data("blk_d9", 6'h33);
        tick(); check_output("blk_e10", 7'b01_10100); check_data("blk_d10", 6'h07);

        // Active drops after two pops of a weight-4 turn.
        do_reset();
        active     = 1'b0;
        vc0_empty  = 1'b1;
        vc1_empty  = 1'b1;
        weight_vc0 = 4'd4;
        tick();
        reset     = 1'b1;
        active    = 1'b1;
        vc0_empty = 1'b0;
        tick(); check_output("act_f1", 7'b01_00000);
        tick(); check_output("act_f2", 7'b01_10000);
        tick(); check_output("act_f3", 7'b01_10000);
        active = 1'b0;
        tick(); check_output("act_f4", 7'b00_00010); check_data("act_d4", 6'h25);
        tick(); check_output("act_f5", 7'b00_00100); check_data("act_d5", 6'h0A);
        tick(); check_output("act_f6", 7'b00_00000);
        tick(); check_output("act_f7", 7'b00_00000);

        $display("%0d/%0d checks passed", check_count - fail_count, check_count);
        $finish;
    end

endmodule
